// File: rtl/dlatch_wr_ctrl_pkg.sv
// Shared state encodings and default timing constants for the latch write controller.
package dlatch_wr_ctrl_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned SETUP_CYC_DEF = 1;
  localparam int unsigned OPEN_CYC_DEF  = 2;
  localparam int unsigned HOLD_CYC_DEF  = 1;
  localparam int unsigned CNT_W_DEF     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_OPEN  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLR   = 3'd4
  } state_e;

endpackage

// File: rtl/dlatch_wr_ctrl_phase_cnt.sv
// Loadable down-counter that stops at zero; zero flag is registered alongside the count.
module phase_cnt
  import dlatch_wr_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/dlatch_wr_ctrl.sv
// Sequences a single-cycle write/clear request into a setup/open/hold latch access
// with busy/done handshake; all outputs registered.
module dlatch_wr_ctrl
  import dlatch_wr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
  parameter int unsigned OPEN_CYC  = OPEN_CYC_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic             clr_req,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             lat_en,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_rst
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lat_en_q, lat_en_d;
  logic             lat_rst_q, lat_rst_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Next state and next output values; outputs describe the state being entered.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lat_en_d  = 1'b0;
    lat_rst_d = 1'b0;
    lat_d_d   = lat_d_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;

    if (clr_req && (state_q != ST_CLR)) begin
      state_d   = ST_CLR;
      busy_d    = 1'b1;
      lat_rst_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
          if (wr_req) begin
            state_d  = ST_SETUP;
            busy_d   = 1'b1;
            lat_d_d  = din;
            cnt_load = 1'b1;
            cnt_val  = SETUP_LD;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            state_d  = ST_OPEN;
            lat_en_d = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = OPEN_LD;
          end
        end
        ST_OPEN: begin
          lat_en_d = 1'b1;
          if (cnt_zero) begin
            state_d  = ST_HOLD;
            lat_en_d = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = HOLD_LD;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        ST_CLR: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lat_en_q  <= 1'b0;
      lat_rst_q <= 1'b1;
      lat_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lat_en_q  <= lat_en_d;
      lat_rst_q <= lat_rst_d;
      lat_d_q   <= lat_d_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign lat_en  = lat_en_q;
  assign lat_rst = lat_rst_q;
  assign lat_d   = lat_d_q;

endmodule

// File: tb/tb_dlatch_wr_ctrl.sv
// Bench for dlatch_wr_ctrl: directed vector table, corner sequences and random traffic
// against an elapsed-time reference model driving a behavioural latch.
module tb_dlatch_wr_ctrl;

  localparam int unsigned W = 8;
  localparam int S = 1;
  localparam int O = 2;
  localparam int H = 1;

  logic         clk = 1'b0;
  logic         rst, wr_req, clr_req;
  logic [W-1:0] din;
  logic         busy, done, lat_en, lat_rst;
  logic [W-1:0] lat_d;

  dlatch_wr_ctrl #(
    .WIDTH(W), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .clr_req(clr_req), .din(din),
    .busy(busy), .done(done), .lat_en(lat_en), .lat_d(lat_d), .lat_rst(lat_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: where we are measured in cycles since the request was accepted
  bit         m_wr_active, m_in_clr;
  int         m_age;
  logic       m_busy, m_done, m_en, m_rst;
  logic [W-1:0] m_d, exp_q;

  logic [W-1:0] latch_q;
  logic         prev_en;
  logic [W-1:0] prev_d;

  typedef struct packed {
    logic         rst, wr, clr;
    logic [W-1:0] din;
    logic         busy, done, en, lrst;
    logic [W-1:0] d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic c, logic [W-1:0] di,
                              logic b, logic dn, logic e, logic lr, logic [W-1:0] d);
    vec_t v;
    v.rst = r; v.wr = w; v.clr = c; v.din = di;
    v.busy = b; v.done = dn; v.en = e; v.lrst = lr; v.d = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic w, input logic c, input logic [W-1:0] di);
    m_done = 1'b0;
    m_en   = 1'b0;
    m_rst  = 1'b0;
    if (r) begin
      m_wr_active = 0; m_in_clr = 0;
      m_busy = 1'b0; m_rst = 1'b1; m_d = '0; exp_q = '0;
    end else if (m_in_clr) begin
      m_in_clr = 0; m_busy = 1'b0; m_done = 1'b1; exp_q = '0;
    end else if (c) begin
      m_wr_active = 0; m_in_clr = 1; m_busy = 1'b1; m_rst = 1'b1;
    end else if (m_wr_active) begin
      m_age++;
      if (m_age == S + O + H + 1) begin
        m_wr_active = 0; m_busy = 1'b0; m_done = 1'b1; exp_q = m_d;
      end else begin
        m_busy = 1'b1;
        m_en   = (m_age > S) && (m_age <= S + O);
      end
    end else if (w) begin
      m_wr_active = 1; m_age = 1; m_busy = 1'b1; m_d = di;
      m_en = (m_age > S) && (m_age <= S + O);
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic w, input logic c, input logic [W-1:0] di);
    rst = r; wr_req = w; clr_req = c; din = di;
    prev_en = lat_en;
    prev_d  = lat_d;
    @(posedge clk);
    model(r, w, c, di);
    #1;
    if (lat_rst)     latch_q = '0;
    else if (lat_en) latch_q = lat_d;
    chk("busy",    32'(busy),    32'(m_busy));
    chk("done",    32'(done),    32'(m_done));
    chk("lat_en",  32'(lat_en),  32'(m_en));
    chk("lat_rst", 32'(lat_rst), 32'(m_rst));
    chk("lat_d",   32'(lat_d),   32'(m_d));
    chk("inv_en_and_rst", 32'(lat_en & lat_rst), 32'd0);
    chk("inv_en_rise_on_d_change",
        32'(lat_en && !prev_en && (lat_d != prev_d)), 32'd0);
    if (m_done) chk("latch_q_after_done", 32'(latch_q), 32'(exp_q));
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; clr_req = 1'b0; din = '0;
    latch_q = 'x; m_d = '0; exp_q = '0; m_age = 0;
    m_wr_active = 0; m_in_clr = 0;

    // reset, single write with a dropped busy write, clear in OPEN, wr+clr in IDLE
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hA5, 1, 0, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'hA5));
    vecs.push_back(mk(0, 1, 0, 8'h3C, 1, 0, 1, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 1, 0, 8'h5A, 1, 0, 0, 0, 8'h5A));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h5A));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 1, 8'h5A));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h5A));
    vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 0, 0, 1, 8'h5A));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h5A));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h5A));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d_busy", i),    32'(busy),    32'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i),    32'(done),    32'(vecs[i].done));
      chk($sformatf("vec%0d_lat_en", i),  32'(lat_en),  32'(vecs[i].en));
      chk($sformatf("vec%0d_lat_rst", i), 32'(lat_rst), 32'(vecs[i].lrst));
      chk($sformatf("vec%0d_lat_d", i),   32'(lat_d),   32'(vecs[i].d));
    end
    chk("latch_q_after_clear", 32'(latch_q), 32'h00);

    // back-to-back writes: second request lands in the done cycle of the first
    step(0, 1, 0, 8'h11);
    for (int i = 0; i < S + O + H; i++) step(0, 0, 0, 8'h00);
    chk("b2b_done_cycle", 32'(done), 32'd1);
    step(0, 1, 0, 8'h22);
    chk("b2b_second_accepted", 32'(lat_d), 32'h22);
    chk("b2b_latch_holds_first", 32'(latch_q), 32'h11);
    for (int i = 0; i < S + O + H + 1; i++) step(0, 0, 0, 8'h00);
    chk("b2b_latch_second", 32'(latch_q), 32'h22);

    // reset during HOLD: reset values next cycle and no done afterwards
    step(0, 1, 0, 8'h77);
    for (int i = 0; i < S + O; i++) step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("rst_in_hold_lat_rst", 32'(lat_rst), 32'd1);
    chk("rst_in_hold_lat_d", 32'(lat_d), 32'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 8'h00);
      chk("rst_in_hold_no_done", 32'(done), 32'd0);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 11) == 0), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
